// File: rtl/mag_cmp_pkg.sv
// Shared relation codes for the unsigned magnitude comparator.
package mag_cmp_pkg;

  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_INVALID = 2'b00;
  localparam cmp_code_t CMP_GT      = 2'b01;
  localparam cmp_code_t CMP_LT      = 2'b10;
  localparam cmp_code_t CMP_EQ      = 2'b11;

  // Code is {lt|eq, gt|eq}, so equality naturally lands on 2'b11.
  function automatic cmp_code_t encode_rel(logic gt, logic lt);
    logic eq;
    eq = ~gt & ~lt;
    return {lt | eq, gt | eq};
  endfunction

endpackage

// File: rtl/mag_compare_4bit_if.sv
// Operand/result bundle for mag_compare_4bit.
interface mag_compare_4bit_if #(
  parameter int unsigned WIDTH = 4
);
  import mag_cmp_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  cmp_code_t        o;
  logic             out_valid;

  // Producer of operands, consumer of the relation code.
  modport master (
    output in_valid,
    output a,
    output b,
    input  o,
    input  out_valid
  );

  // The comparator itself.
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output o,
    output out_valid
  );

endinterface

// File: rtl/mag_cmp_slice.sv
// One bit of the MSB-first compare cascade. Once a higher bit has decided
// the relation it is forwarded untouched; otherwise this bit decides.
module mag_cmp_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic gt_in,
  input  logic lt_in,
  output logic gt_out,
  output logic lt_out
);

  // Pass through an upstream decision, else compare this bit.
  always_comb begin
    gt_out = gt_in;
    lt_out = lt_in;
    if (!gt_in && !lt_in) begin
      gt_out = a_i & ~b_i;
      lt_out = ~a_i & b_i;
    end
  end

endmodule

// File: rtl/mag_compare_4bit.sv
// Registered unsigned magnitude comparator: relation code one cycle after a
// valid operand pair, 2'b00 when no result is held.
module mag_compare_4bit
  import mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  mag_compare_4bit_if.slave  bus
);

  logic [WIDTH:0] gt_chain;
  logic [WIDTH:0] lt_chain;
  cmp_code_t      code;
  logic           in_unknown;
  cmp_code_t      o_q;
  logic           out_valid_q;

  // The MSB slice starts from an undecided state.
  assign gt_chain[WIDTH] = 1'b0;
  assign lt_chain[WIDTH] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    mag_cmp_slice u_slice (
      .a_i    (bus.a[i]),
      .b_i    (bus.b[i]),
      .gt_in  (gt_chain[i+1]),
      .lt_in  (lt_chain[i+1]),
      .gt_out (gt_chain[i]),
      .lt_out (lt_chain[i])
    );
  end

  // Encode the LSB-end cascade result; flag X/Z operands in simulation.
  always_comb begin
    code       = encode_rel(gt_chain[0], lt_chain[0]);
    in_unknown = $isunknown({bus.a, bus.b});
  end

  // Output register: a bubble clears the result rather than holding it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q         <= CMP_INVALID;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      o_q         <= in_unknown ? CMP_INVALID : code;
      out_valid_q <= 1'b1;
    end else begin
      o_q         <= CMP_INVALID;
      out_valid_q <= 1'b0;
    end
  end

  assign bus.o         = o_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mag_compare_4bit.sv
// Self-checking bench for mag_compare_4bit.
module tb_mag_compare_4bit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mag_compare_4bit_if #(.WIDTH(4)) bus ();

  mag_compare_4bit #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] exp_o;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Present one sample at the falling edge; outputs are sampled 1 time unit
  // after the following rising edge.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_code(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 2'b01;
    if (a < b) return 2'b10;
    return 2'b11;
  endfunction

  logic       probe;
  logic       four_state;
  logic [3:0] xa;

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd3,  exp_o: 2'b01};
    vecs[1] = '{a: 4'd2,  b: 4'd11, exp_o: 2'b10};
    vecs[2] = '{a: 4'd7,  b: 4'd7,  exp_o: 2'b11};
    vecs[3] = '{a: 4'd15, b: 4'd0,  exp_o: 2'b01};
    vecs[4] = '{a: 4'd0,  b: 4'd15, exp_o: 2'b10};

    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    // Held in reset across an edge.
    @(posedge clk);
    #1;
    check("reset_o", bus.o, 2'b00);
    check("reset_valid", {1'b0, bus.out_valid}, 2'b00);

    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 4'd0, 4'd0);
    check("idle_o", bus.o, 2'b00);
    check("idle_valid", {1'b0, bus.out_valid}, 2'b00);

    // Directed table.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("dir%0d_o", i), bus.o, vecs[i].exp_o);
      check($sformatf("dir%0d_valid", i), {1'b0, bus.out_valid}, 2'b01);
    end

    // Asynchronous reset mid-cycle clears the held result immediately.
    step(1'b1, 4'd9, 4'd3);
    check("pre_async_o", bus.o, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_o", bus.o, 2'b00);
    check("async_rst_valid", {1'b0, bus.out_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 4'(i >> 4), 4'(i & 15));
      check($sformatf("sweep_%0d_%0d", i >> 4, i & 15), bus.o,
            ref_code(4'(i >> 4), 4'(i & 15)));
      check("sweep_valid", {1'b0, bus.out_valid}, 2'b01);
    end

    // Unknown operand bit. A two-state simulator cannot carry X, so the code
    // is only checked where X survives.
    probe      = 1'bx;
    four_state = $isunknown(probe);
    xa         = 4'b1x01;
    step(1'b1, xa, 4'd3);
    if (four_state) check("x_in_o", bus.o, 2'b00);
    check("x_in_valid", {1'b0, bus.out_valid}, 2'b01);
    step(1'b1, 4'd5, 4'd5);
    check("after_x_o", bus.o, 2'b11);

    // Bubble pattern 1,0,1.
    step(1'b1, 4'd1, 4'd2);
    check("bub0_o", bus.o, 2'b10);
    check("bub0_valid", {1'b0, bus.out_valid}, 2'b01);
    step(1'b0, 4'd1, 4'd2);
    check("bub1_o", bus.o, 2'b00);
    check("bub1_valid", {1'b0, bus.out_valid}, 2'b00);
    step(1'b1, 4'd3, 4'd3);
    check("bub2_o", bus.o, 2'b11);
    check("bub2_valid", {1'b0, bus.out_valid}, 2'b01);

    // Reset while a valid sample is in flight: it is discarded.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 4'd9;
    bus.b        = 4'd3;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("inflight_rst_o", bus.o, 2'b00);
    check("inflight_rst_valid", {1'b0, bus.out_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    bus.a = 4'd6;
    bus.b = 4'd6;
    @(posedge clk);
    #1;
    check("post_rst_o", bus.o, 2'b11);
    check("post_rst_valid", {1'b0, bus.out_valid}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
